// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and defaults for the IF spike decoder
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_t;

    localparam int DEF_NUM_NEURONS = 10;
    localparam int DEF_COUNT_WIDTH = 16;
    localparam int DEF_WINDOW      = 350;
    localparam int DEF_WIN_WIDTH   = 16;

    // Never narrower than one bit, even for a single-neuron layer.
    function automatic int class_width_for(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CLASS_WIDTH = class_width_for(DEF_NUM_NEURONS);

endpackage

// File: rtl/spike_counter.sv
// rtl/spike_counter.sv - saturating per-neuron spike counter with clear and enable
module spike_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/if_spike_decoder.sv
// rtl/if_spike_decoder.sv - windowed spike counting and winner-take-all classification
module if_spike_decoder
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int WIN_WIDTH   = DEF_WIN_WIDTH,
    parameter int CLASS_WIDTH = class_width_for(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   step_en,
    input  logic                   start,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CLASS_WIDTH-1:0] result_class,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic                   result_none
);

    localparam int NUM_SLOTS = 2 ** CLASS_WIDTH;
    localparam logic [WIN_WIDTH-1:0]   LP_LAST_STEP = WIN_WIDTH'(WINDOW - 1);
    localparam logic [CLASS_WIDTH-1:0] LP_LAST_IDX  = CLASS_WIDTH'(NUM_NEURONS - 1);

    dec_state_t             r_state;
    dec_state_t             w_state_next;
    logic [WIN_WIDTH-1:0]   r_step;
    logic [CLASS_WIDTH-1:0] r_scan_idx;
    logic [CLASS_WIDTH-1:0] r_best_idx;
    logic [COUNT_WIDTH-1:0] r_best_cnt;
    logic [CLASS_WIDTH-1:0] r_result_class;
    logic [COUNT_WIDTH-1:0] r_result_count;
    logic                   r_result_none;

    logic                   w_clr;
    logic                   w_sample;
    logic                   w_last_step;
    logic                   w_last_scan;
    logic                   w_better;
    logic [COUNT_WIDTH-1:0] w_sel_cnt;
    logic [CLASS_WIDTH-1:0] w_fin_idx;
    logic [COUNT_WIDTH-1:0] w_fin_cnt;
    logic [COUNT_WIDTH-1:0] w_counts [NUM_SLOTS];

    assign w_clr       = (r_state == ST_IDLE) && start;
    assign w_sample    = (r_state == ST_COUNT) && step_en;
    assign w_last_step = (r_step == LP_LAST_STEP);
    assign w_last_scan = (r_scan_idx == LP_LAST_IDX);

    // Slots past NUM_NEURONS read as zero so the scan mux index spans the full class width.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        if (gi < NUM_NEURONS) begin : g_cnt
            spike_counter #(
                .COUNT_WIDTH(COUNT_WIDTH)
            ) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .i_clr   (w_clr),
                .i_en    (w_sample & spike_in[gi]),
                .o_count (w_counts[gi])
            );
        end else begin : g_pad
            assign w_counts[gi] = '0;
        end
    end

    assign w_sel_cnt = w_counts[r_scan_idx];
    assign w_better  = (w_sel_cnt > r_best_cnt);
    assign w_fin_idx = w_better ? r_scan_idx : r_best_idx;
    assign w_fin_cnt = w_better ? w_sel_cnt : r_best_cnt;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_COUNT;
            ST_COUNT: if (w_sample && w_last_step) w_state_next = ST_SCAN;
            ST_SCAN:  if (w_last_scan) w_state_next = ST_DONE;
            ST_DONE:  if (result_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_step         <= '0;
            r_scan_idx     <= '0;
            r_best_idx     <= '0;
            r_best_cnt     <= '0;
            r_result_class <= '0;
            r_result_count <= '0;
            r_result_none  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_clr) begin
                r_step <= '0;
            end else if (w_sample) begin
                r_step <= r_step + WIN_WIDTH'(1);
            end

            // Best starts at zero with strict compare, so neuron 0 wins ties and empty windows.
            if (r_state == ST_COUNT) begin
                r_scan_idx <= '0;
                r_best_idx <= '0;
                r_best_cnt <= '0;
            end else if (r_state == ST_SCAN) begin
                r_scan_idx <= r_scan_idx + CLASS_WIDTH'(1);
                r_best_idx <= w_fin_idx;
                r_best_cnt <= w_fin_cnt;
                if (w_last_scan) begin
                    r_result_class <= w_fin_idx;
                    r_result_count <= w_fin_cnt;
                    r_result_none  <= (w_fin_cnt == '0);
                end
            end
        end
    end

    assign busy         = (r_state == ST_COUNT) || (r_state == ST_SCAN);
    assign result_valid = (r_state == ST_DONE);
    assign result_class = r_result_class;
    assign result_count = r_result_count;
    assign result_none  = r_result_none;

endmodule

// File: tb/tb_if_spike_decoder.sv
// tb/tb_if_spike_decoder.sv - randomized self-checking bench for if_spike_decoder
module tb_if_spike_decoder;

    localparam int NN   = 4;
    localparam int CW   = 2;
    localparam int WIN  = 6;
    localparam int WW   = 8;
    localparam int CLW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NN-1:0]  spike_in;
    logic           step_en;
    logic           start;
    logic           busy;
    logic           result_valid;
    logic           result_ready;
    logic [CLW-1:0] result_class;
    logic [CW-1:0]  result_count;
    logic           result_none;

    int checks   = 0;
    int failures = 0;

    if_spike_decoder #(
        .NUM_NEURONS (NN),
        .COUNT_WIDTH (CW),
        .WINDOW      (WIN),
        .WIN_WIDTH   (WW),
        .CLASS_WIDTH (CLW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spike_in     (spike_in),
        .step_en      (step_en),
        .start        (start),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_count (result_count),
        .result_none  (result_none)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NN-1:0] gen_spikes(input int smode, input int step);
        case (smode)
            0:       return '0;
            1:       return 4'b0100;
            2:       return (step < 2) ? 4'b1010 : 4'b0000;
            4:       return (step < 2) ? 4'b0100 : 4'b0000;
            default: return NN'($urandom);
        endcase
    endfunction

    // smode: spike pattern; gmode: 0 step every cycle, 1 every other cycle, 2 random;
    // hold: cycles of backpressure in DONE; abort: reset asynchronously mid-scan.
    task automatic run_window(input int smode, input int gmode, input int hold, input bit abort);
        int cnt [NN];
        int samp = 0;
        int ccyc = 0;
        int sc   = 0;
        int exp_cnt = 0;
        int exp_cls = 0;
        logic [NN-1:0] v;
        foreach (cnt[i]) cnt[i] = 0;

        start = 1'b1; step_en = 1'b0; result_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_in_count", busy, 1);

        while (samp < WIN && ccyc < 200) begin
            case (gmode)
                0:       step_en = 1'b1;
                1:       step_en = (ccyc % 2) == 1;
                default: step_en = $urandom_range(0, 1) == 1;
            endcase
            v = step_en ? gen_spikes(smode, samp) : NN'($urandom);
            spike_in = v;
            start = $urandom_range(0, 1) == 1;
            if (step_en) begin
                for (int i = 0; i < NN; i++) cnt[i] += int'(v[i]);
                samp++;
            end
            ccyc++;
            tick();
        end
        step_en = 1'b0;
        if (gmode == 0) chk("count_cycles", ccyc, WIN);
        if (gmode == 1) chk("count_cycles_gated", ccyc, 2 * WIN);

        if (abort) begin
            tick();
            tick();
            start = 1'b0;
            #2 rst = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_valid", result_valid, 0);
            chk("rst_class", result_class, 0);
            chk("rst_count", result_count, 0);
            chk("rst_none", result_none, 0);
            rst = 1'b1;
            tick();
            chk("rst_idle", busy, 0);
            return;
        end

        while (!result_valid && sc < 50) begin
            chk("busy_in_scan", busy, 1);
            start = $urandom_range(0, 1) == 1;
            spike_in = NN'($urandom);
            tick();
            sc++;
        end
        start = 1'b0;
        chk("scan_cycles", sc, NN);
        if (gmode == 0) chk("latency", 1 + ccyc + sc, WIN + NN + 1);

        for (int i = 0; i < NN; i++) begin
            int s;
            s = (cnt[i] > CMAX) ? CMAX : cnt[i];
            if (s > exp_cnt) begin
                exp_cnt = s;
                exp_cls = i;
            end
        end

        chk("valid", result_valid, 1);
        chk("busy_done", busy, 0);
        chk("class", result_class, exp_cls);
        chk("count", result_count, exp_cnt);
        chk("none", result_none, (exp_cnt == 0) ? 1 : 0);

        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", result_valid, 1);
            chk("hold_class", result_class, exp_cls);
            chk("hold_count", result_count, exp_cnt);
        end

        result_ready = 1'b1;
        start = 1'b1;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        chk("post_valid", result_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_class_held", result_class, exp_cls);
        chk("post_count_held", result_count, exp_cnt);
        tick();
        chk("start_in_done_ignored", busy, 0);
    endtask

    initial begin
        rst = 1'b0;
        spike_in = '0;
        step_en = 1'b0;
        start = 1'b0;
        result_ready = 1'b0;
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_class", result_class, 0);
        chk("reset_count", result_count, 0);
        chk("reset_none", result_none, 0);
        rst = 1'b1;
        tick();

        run_window(1, 0, 0, 1'b0);
        run_window(4, 0, 2, 1'b0);
        run_window(2, 0, 0, 1'b0);
        run_window(0, 0, 1, 1'b0);
        run_window(4, 1, 5, 1'b0);
        run_window(1, 0, 0, 1'b0);
        run_window(3, 0, 0, 1'b1);
        run_window(4, 0, 0, 1'b0);
        for (int r = 0; r < 25; r++) begin
            run_window(3, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
